s2p_receiver: RTL and testbench
===============================

Name: s2p_receiver

Overview:
- Serial-to-parallel receiver. It is the far end of the team's P2S serial link.
- It collects DATA_BITS serial bits qualified by a bit-valid strobe and assembles them into a parallel word.
- It presents the word with a valid/acknowledge handshake to the consuming logic.
- It detects mid-frame stalls (timeout) and unconsumed-word overwrites (overrun).

Parameters:
- DATA_BITS, 16, width of the assembled word.
- DATA_COUNT_BITS, 4, width of the bit counter; must satisfy 2^DATA_COUNT_BITS >= DATA_BITS.
- DIR, 0, bit order: 0 = first received bit is the MSB (shift left); 1 = first received bit is the LSB (shift right).
- TIMEOUT, 255, maximum clk cycles allowed between two bit strobes inside a frame; 8-bit gap counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit.
- s_valid  input  1  bit strobe; sin is captured on a rising clk edge where s_valid=1.
- s_clrn  input  1  synchronous active-low frame clear; discards any partial frame.
- RdAck  input  1  consumer acknowledge of PData.
- PData  output  DATA_BITS  last completed word, held until the next completion.
- DValid  output  1  PData holds an unacknowledged word.
- Done  output  1  one-cycle pulse on frame completion.
- Busy  output  1  a frame is in progress (at least one bit received, not yet complete).
- Overrun  output  1  sticky flag; a completion occurred while DValid=1.
- Timeout  output  1  one-cycle pulse when a partial frame is aborted by the gap limit.

Behaviour:
- Reset (rst=0, asynchronous): all of the following are cleared to 0:
  - shift register, PData, bit counter, gap counter;
  - DValid, Done, Busy, Overrun, Timeout.
  - State goes to IDLE. Reset mid-frame discards the partial word; PData is also cleared.
- State IDLE:
  - s_valid=1 captures the first bit, sets count=1, clears the gap counter, and goes to RECV.
  - Special case DATA_BITS=1: the frame completes immediately (see completion).
- State RECV:
  - Each s_valid=1 shifts sin in and increments count.
  - DIR=0: shreg <= {shreg[DATA_BITS-2:0], sin}.
  - DIR=1: shreg <= {sin, shreg[DATA_BITS-1:1]}.
  - On the strobe that makes count reach DATA_BITS, the frame completes.
- Completion, registered at the same edge as the last bit:
  - PData <= the fully assembled word, including the final bit.
  - Done=1 for exactly one cycle; DValid=1.
  - count cleared; state returns to IDLE; Busy=0.
  - A strobe in the very next cycle starts a new frame without penalty, so back-to-back frames are allowed.
- Latency: PData, DValid and Done are visible in the cycle immediately after the edge that captured the last bit.
- Busy is 1 exactly while state=RECV.
- Gap timer:
  - In RECV, the gap counter increments on every cycle with s_valid=0 and clears on s_valid=1.
  - When it reaches TIMEOUT with s_valid still 0: partial frame discarded, Timeout pulses for 1 cycle, state goes to IDLE.
  - PData and DValid are unaffected by a timeout.
  - The gap counter does not run in IDLE.
- s_clrn=0, synchronous, has priority over s_valid:
  - Clears the shift register, count and gap counter; state goes to IDLE; Busy=0.
  - Does not touch PData, DValid or Overrun; no Timeout pulse.
- Handshake:
  - RdAck=1 while DValid=1 clears DValid on the next edge.
  - RdAck with DValid=0 is ignored.
- Simultaneous completion and RdAck in the same cycle: the new word is loaded, DValid stays 1, Overrun is not set (the old word counts as consumed).
- Completion with DValid=1 and no RdAck: the new word overwrites PData and Overrun becomes 1.
- Overrun is cleared only by reset.
- Strobes in IDLE with s_clrn=0 are discarded.
- Bit counter never exceeds DATA_BITS; no wrap-around is possible.

Test Plan:
- DIR=0, DATA_BITS=16: strobe 16 consecutive bits of 0xA53C MSB-first -> next cycle PData=16'hA53C, Done one cycle, DValid=1, Busy=0.
- DIR=1: strobe 0xA53C LSB-first with 3 idle cycles between each bit -> PData=16'hA53C; no Timeout; Busy high from the first bit through the 16th capture.
- Two frames back-to-back (0x1234 then 0xFFFF) with no RdAck -> second Done, PData=16'hFFFF, Overrun=1.
- Repeat with RdAck asserted in the same cycle as the second completion -> Overrun=0, DValid=1.
- TIMEOUT=4: send 5 bits, then hold s_valid=0 -> Timeout pulses 4 cycles after the 5th strobe, Busy=0, PData unchanged. A following full 0x00FF frame is received correctly.
- Send 8 bits, pulse s_clrn=0 for one cycle together with s_valid=1 -> bit discarded, Busy=0, no Timeout. A subsequent 0xBEEF frame yields PData=16'hBEEF.
- Drop rst to 0 asynchronously (between clk edges) mid-frame with DValid=1 -> all outputs 0 immediately. After release, a complete 0x0001 frame yields PData=16'h0001, Overrun=0.

Source files
------------

// File: rtl/s2p_receiver.sv
// Serial-to-parallel receiver: assembles DATA_BITS strobed serial bits into a word
// and hands it to the consumer with a valid/acknowledge handshake.
module s2p_receiver #(
    parameter int unsigned DATA_BITS       = 16,
    parameter int unsigned DATA_COUNT_BITS = 4,
    parameter int unsigned DIR             = 0,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sin,
    input  logic                 s_valid,
    input  logic                 s_clrn,
    input  logic                 RdAck,
    output logic [DATA_BITS-1:0] PData,
    output logic                 DValid,
    output logic                 Done,
    output logic                 Busy,
    output logic                 Overrun,
    output logic                 Timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // The counter never holds DATA_BITS itself: the final strobe completes and clears it.
    localparam logic [DATA_COUNT_BITS-1:0] CNT_LAST = DATA_COUNT_BITS'(DATA_BITS - 1);
    localparam logic [7:0]                 GAP_LAST = 8'(TIMEOUT - 1);

    state_t                     state_q, state_d;
    logic [DATA_BITS-1:0]       shreg_q, shreg_d;
    logic [DATA_BITS-1:0]       pdata_q, pdata_d;
    logic [DATA_COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [7:0]                 gap_q, gap_d;
    logic                       dvalid_q, dvalid_d;
    logic                       done_q, done_d;
    logic                       overrun_q, overrun_d;
    logic                       timeout_q, timeout_d;

    logic [DATA_BITS-1:0]       shift_in;
    logic                       clr;
    logic                       take;
    logic                       complete;
    logic                       abort;

    generate
        if (DATA_BITS == 1) begin : g_single
            assign shift_in = sin;
        end else if (DIR == 0) begin : g_msb_first
            assign shift_in = {shreg_q[DATA_BITS-2:0], sin};
        end else begin : g_lsb_first
            assign shift_in = {sin, shreg_q[DATA_BITS-1:1]};
        end
    endgenerate

    // Event decode; cnt_q is always zero in IDLE, so one compare serves both states.
    always_comb begin
        clr      = ~s_clrn;
        take     = s_clrn & s_valid;
        complete = take & (cnt_q == CNT_LAST);
        abort    = s_clrn & ~s_valid & (state_q == RECV) & (gap_q == GAP_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take && !complete) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (clr || complete || abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        pdata_d   = pdata_q;
        dvalid_d  = dvalid_q;
        overrun_d = overrun_q;
        done_d    = complete;
        timeout_d = abort;

        if (clr) begin
            shreg_d = '0;
            cnt_d   = '0;
            gap_d   = '0;
        end else if (take) begin
            shreg_d = shift_in;
            gap_d   = '0;
            cnt_d   = complete ? '0 : cnt_q + 1'b1;
        end else if (abort) begin
            cnt_d = '0;
            gap_d = '0;
        end else if (state_q == RECV) begin
            gap_d = gap_q + 8'd1;
        end

        // A same-cycle acknowledge consumes the old word, so it is not an overrun.
        if (complete) begin
            pdata_d  = shift_in;
            dvalid_d = 1'b1;
            if (dvalid_q && !RdAck) begin
                overrun_d = 1'b1;
            end
        end else if (RdAck) begin
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q   <= '0;
            pdata_q   <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            dvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            pdata_q   <= pdata_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            dvalid_q  <= dvalid_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        PData   = pdata_q;
        DValid  = dvalid_q;
        Done    = done_q;
        Busy    = (state_q == RECV);
        Overrun = overrun_q;
        Timeout = timeout_q;
    end

endmodule

// File: tb/tb_s2p_receiver.sv
// Directed plus randomized bench for s2p_receiver; three instances share one serial
// stream and are each checked every cycle against a bit-list reference model.
module tb_s2p_receiver;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sin = 1'b0;
    logic s_valid = 1'b0;
    logic s_clrn = 1'b1;
    logic RdAck = 1'b0;

    logic [15:0] pd [3];
    logic        dv [3];
    logic        dn [3];
    logic        by [3];
    logic        ov [3];
    logic        to [3];

    int errors = 0;
    int checks = 0;

    // Instance configuration: {DIR, TIMEOUT}
    int cfg_dir [3] = '{0, 1, 0};
    int cfg_to  [3] = '{255, 4, 4};

    // Reference model state
    int          m_nb  [3];
    int          m_gap [3];
    bit          m_rx  [3][16];
    logic [15:0] m_pd  [3];
    bit          m_dv  [3];
    bit          m_dn  [3];
    bit          m_ov  [3];
    bit          m_to  [3];

    always #5 clk = ~clk;

    s2p_receiver #(.DATA_BITS(16), .DATA_COUNT_BITS(4), .DIR(0), .TIMEOUT(255)) u_a (
        .clk(clk), .rst(rst), .sin(sin), .s_valid(s_valid), .s_clrn(s_clrn), .RdAck(RdAck),
        .PData(pd[0]), .DValid(dv[0]), .Done(dn[0]), .Busy(by[0]), .Overrun(ov[0]), .Timeout(to[0])
    );

    s2p_receiver #(.DATA_BITS(16), .DATA_COUNT_BITS(4), .DIR(1), .TIMEOUT(4)) u_b (
        .clk(clk), .rst(rst), .sin(sin), .s_valid(s_valid), .s_clrn(s_clrn), .RdAck(RdAck),
        .PData(pd[1]), .DValid(dv[1]), .Done(dn[1]), .Busy(by[1]), .Overrun(ov[1]), .Timeout(to[1])
    );

    s2p_receiver #(.DATA_BITS(16), .DATA_COUNT_BITS(4), .DIR(0), .TIMEOUT(4)) u_c (
        .clk(clk), .rst(rst), .sin(sin), .s_valid(s_valid), .s_clrn(s_clrn), .RdAck(RdAck),
        .PData(pd[2]), .DValid(dv[2]), .Done(dn[2]), .Busy(by[2]), .Overrun(ov[2]), .Timeout(to[2])
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int k);
        m_nb[k]  = 0;
        m_gap[k] = 0;
        m_pd[k]  = '0;
        m_dv[k]  = 1'b0;
        m_dn[k]  = 1'b0;
        m_ov[k]  = 1'b0;
        m_to[k]  = 1'b0;
        for (int i = 0; i < 16; i++) m_rx[k][i] = 1'b0;
    endtask

    // Word value from the list of received bits: bit i of the frame has weight
    // 2^(15-i) when MSB-first, 2^i when LSB-first.
    function automatic logic [15:0] assemble(input int k);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            if (m_rx[k][i]) w = w + ((cfg_dir[k] == 0) ? (16'd1 << (15 - i)) : (16'd1 << i));
        end
        return w;
    endfunction

    task automatic model_edge();
        bit          comp;
        bit          tmo;
        logic [15:0] w;
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                model_clear(k);
            end else begin
                comp = 1'b0;
                tmo  = 1'b0;
                w    = '0;
                if (!s_clrn) begin
                    m_nb[k]  = 0;
                    m_gap[k] = 0;
                end else if (s_valid) begin
                    m_rx[k][m_nb[k]] = sin;
                    m_nb[k]  = m_nb[k] + 1;
                    m_gap[k] = 0;
                    if (m_nb[k] == 16) begin
                        comp    = 1'b1;
                        w       = assemble(k);
                        m_nb[k] = 0;
                    end
                end else if (m_nb[k] > 0) begin
                    if (m_gap[k] + 1 >= cfg_to[k]) begin
                        tmo      = 1'b1;
                        m_nb[k]  = 0;
                        m_gap[k] = 0;
                    end else begin
                        m_gap[k] = m_gap[k] + 1;
                    end
                end
                if (comp) begin
                    if (m_dv[k] && !RdAck) m_ov[k] = 1'b1;
                    m_pd[k] = w;
                    m_dv[k] = 1'b1;
                end else if (RdAck) begin
                    m_dv[k] = 1'b0;
                end
                m_dn[k] = comp;
                m_to[k] = tmo;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("PData[%0d]", k),   pd[k],         m_pd[k]);
            chk($sformatf("DValid[%0d]", k),  16'(dv[k]),    16'(m_dv[k]));
            chk($sformatf("Done[%0d]", k),    16'(dn[k]),    16'(m_dn[k]));
            chk($sformatf("Busy[%0d]", k),    16'(by[k]),    16'(m_nb[k] > 0));
            chk($sformatf("Overrun[%0d]", k), 16'(ov[k]),    16'(m_ov[k]));
            chk($sformatf("Timeout[%0d]", k), 16'(to[k]),    16'(m_to[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        #3;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) model_clear(k);
        #1;
        check_all();
        repeat (2) tick();
        #2;
        rst = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] w, input bit lsb_first, input int gap, input bit ack_last);
        for (int i = 0; i < 16; i++) begin
            sin     = lsb_first ? w[i] : w[15-i];
            s_valid = 1'b1;
            if (ack_last && i == 15) RdAck = 1'b1;
            tick();
            s_valid = 1'b0;
            RdAck   = 1'b0;
            if (i != 15) repeat (gap) tick();
        end
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            sin     = 1'($urandom_range(0, 1));
            s_valid = 1'b1;
            tick();
            s_valid = 1'b0;
        end
    endtask

    task automatic ack_once();
        RdAck = 1'b1;
        tick();
        RdAck = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) model_clear(k);
        #1;
        check_all();
        repeat (2) tick();
        #2;
        rst = 1'b1;
        tick();

        // MSB-first contiguous frame
        send_word(16'hA53C, 1'b0, 0, 1'b0);
        chk("msb_pdata", pd[0], 16'hA53C);
        chk("msb_done",  16'(dn[0]), 16'd1);
        chk("msb_dvalid", 16'(dv[0]), 16'd1);
        chk("msb_busy",  16'(by[0]), 16'd0);
        tick();
        chk("msb_done_pulse", 16'(dn[0]), 16'd0);
        ack_once();

        // LSB-first with three idle cycles between strobes (just below a gap limit of 4)
        send_word(16'hA53C, 1'b1, 3, 1'b0);
        chk("lsb_pdata", pd[1], 16'hA53C);
        chk("lsb_timeout", 16'(to[1]), 16'd0);
        ack_once();
        tick();

        // Back-to-back frames without acknowledge
        send_word(16'h1234, 1'b0, 0, 1'b0);
        send_word(16'hFFFF, 1'b0, 0, 1'b0);
        chk("b2b_pdata", pd[0], 16'hFFFF);
        chk("b2b_overrun", 16'(ov[0]), 16'd1);
        tick();

        // Same again with acknowledge coinciding with the second completion
        do_reset();
        tick();
        send_word(16'h1234, 1'b0, 0, 1'b0);
        send_word(16'hFFFF, 1'b0, 0, 1'b1);
        chk("ackc_overrun", 16'(ov[0]), 16'd0);
        chk("ackc_dvalid", 16'(dv[0]), 16'd1);
        chk("ackc_pdata", pd[0], 16'hFFFF);

        // Gap timeout after 5 bits on the TIMEOUT=4 instance
        send_bits(5);
        repeat (3) begin
            tick();
            chk("tmo_early", 16'(to[2]), 16'd0);
        end
        tick();
        chk("tmo_pulse", 16'(to[2]), 16'd1);
        chk("tmo_busy", 16'(by[2]), 16'd0);
        chk("tmo_pdata", pd[2], 16'hFFFF);
        repeat (260) tick();
        chk("tmo255_busy", 16'(by[0]), 16'd0);
        send_word(16'h00FF, 1'b0, 0, 1'b0);
        chk("after_tmo_pdata", pd[2], 16'h00FF);
        chk("after_tmo255_pdata", pd[0], 16'h00FF);
        ack_once();

        // Frame clear with a coincident strobe
        send_bits(8);
        s_clrn  = 1'b0;
        s_valid = 1'b1;
        sin     = 1'b1;
        tick();
        s_clrn  = 1'b1;
        s_valid = 1'b0;
        chk("clr_busy", 16'(by[0]), 16'd0);
        chk("clr_timeout", 16'(to[2]), 16'd0);
        send_word(16'hBEEF, 1'b0, 0, 1'b0);
        chk("clr_pdata", pd[0], 16'hBEEF);

        // Asynchronous reset mid-frame with an unconsumed word
        send_bits(5);
        chk("pre_rst_dvalid", 16'(dv[0]), 16'd1);
        do_reset();
        tick();
        send_word(16'h0001, 1'b0, 0, 1'b0);
        chk("post_rst_pdata", pd[0], 16'h0001);
        chk("post_rst_overrun", 16'(ov[0]), 16'd0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            sin     = 1'($urandom_range(0, 1));
            s_valid = ($urandom_range(0, 3) != 0);
            RdAck   = ($urandom_range(0, 1) != 0);
            s_clrn  = ($urandom_range(0, 59) != 0);
            tick();
            if ($urandom_range(0, 29) == 0) begin
                s_valid = 1'b0;
                RdAck   = 1'b0;
                s_clrn  = 1'b1;
                repeat ($urandom_range(3, 6)) tick();
            end
        end
        s_valid = 1'b0;
        RdAck   = 1'b0;
        s_clrn  = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
